trigger_detector_hyst: RTL

Parametrised threshold trigger for the rangefinder receive path. It compares each ADC sample against a programmable threshold and emits a one-cycle `trigger` pulse on a rising or falling crossing. Hysteresis re-arming suppresses noise chatter, and a programmable holdoff blanks retriggers after each pulse. Single-shot and continuous modes are supported, and the sample-count timestamp of each trigger is latched for the time-of-flight logic downstream.

---
 rtl/trigger_detector_hyst.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/trigger_detector_hyst.sv
// Threshold trigger with hysteresis re-arm, programmable holdoff and a
// sample-count timestamp latched at each trigger.
module trigger_detector_hyst #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] hysteresis,
  input  logic              direction,
  input  logic              single_shot,
  input  logic              arm,
  input  logic [CNT_W-1:0]  holdoff,
  output logic              trigger,
  output logic [CNT_W-1:0]  trig_time,
  output logic              armed,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ARM = 2'd1,
    S_ARMED    = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic               fire_q, fire_d;
  logic               rearm_q, rearm_d;
  logic               dir_q;
  logic               trigger_q, trigger_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   trig_time_q, trig_time_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   ts_cnt_q, ts_cnt_d;

  logic [DATA_W:0]    lo_ext, hi_ext;
  logic [DATA_W-1:0]  lo, hi;
  logic               dir_change;
  state_e             post_target;

  // Stage 1: hysteresis band edges with one extra bit so they saturate instead of wrapping
  always_comb begin
    lo_ext  = {1'b0, threshold} - {1'b0, hysteresis};
    hi_ext  = {1'b0, threshold} + {1'b0, hysteresis};
    lo      = lo_ext[DATA_W] ? '0 : lo_ext[DATA_W-1:0];
    hi      = hi_ext[DATA_W] ? '1 : hi_ext[DATA_W-1:0];
    fire_d  = direction ? (sample >= threshold) : (sample <= threshold);
    rearm_d = direction ? (sample < lo) : (sample > hi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_q  <= 1'b0;
      rearm_q <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      fire_q  <= fire_d;
      rearm_q <= rearm_d;
      dir_q   <= direction;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      trigger_q   <= 1'b0;
      armed_q     <= 1'b0;
      trig_time_q <= '0;
      hold_cnt_q  <= '0;
      ts_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      trigger_q   <= trigger_d;
      armed_q     <= armed_d;
      trig_time_q <= trig_time_d;
      hold_cnt_q  <= hold_cnt_d;
      ts_cnt_q    <= ts_cnt_d;
    end
  end

  // Stage 2: arming FSM, holdoff counter and timestamp
  always_comb begin
    state_d     = state_q;
    trigger_d   = 1'b0;
    trig_time_d = trig_time_q;
    hold_cnt_d  = hold_cnt_q;
    ts_cnt_d    = ts_cnt_q;
    dir_change  = (direction != dir_q);
    post_target = single_shot ? S_IDLE : S_WAIT_ARM;

    if (state_q != S_IDLE && ts_cnt_q != CNT_MAX) begin
      ts_cnt_d = ts_cnt_q + CNT_W'(1);
    end

    if (!enable) begin
      state_d    = S_IDLE;
      hold_cnt_d = '0;
      ts_cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!single_shot || arm) begin
            state_d  = S_WAIT_ARM;
            ts_cnt_d = '0;
          end
        end
        S_WAIT_ARM: begin
          if (!dir_change && rearm_q) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (dir_change) begin
            state_d = S_WAIT_ARM;
          end else if (fire_q) begin
            trigger_d   = 1'b1;
            trig_time_d = ts_cnt_q;
            if (holdoff == '0) begin
              state_d    = post_target;
              hold_cnt_d = '0;
            end else begin
              state_d    = S_HOLDOFF;
              hold_cnt_d = holdoff;
            end
          end
        end
        S_HOLDOFF: begin
          // A zero count can only be reached via reset paths; treat it like the last cycle
          if (hold_cnt_q <= CNT_W'(1)) begin
            state_d    = post_target;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    armed_d = (state_d == S_ARMED);
  end

  assign trigger   = trigger_q;
  assign trig_time = trig_time_q;
  assign armed     = armed_q;
  assign state     = state_q;

endmodule
